// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-file word/index plus load-unit encodings.
package cpu_types_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] index_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } ld_state_t;

    // Attributes of the in-flight load needed once the read word returns.
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lane;
    } ld_ctx_t;

endpackage

// File: rtl/load_align.sv
// Byte-lane extraction and sign/zero extension of a load word, plus legality check.
module load_align
    import cpu_types_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr,
    input  word_t      i_rdata,
    output word_t      o_data_c,
    output logic       o_illegal_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte      = 8'(i_rdata >> {i_addr, 3'b000});
        w_half      = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data_c    = i_rdata;
        o_illegal_c = 1'b0;
        case (i_funct3)
            LB:      o_data_c = {{24{w_byte[7]}}, w_byte};
            LBU:     o_data_c = {24'h000000, w_byte};
            LH: begin
                o_data_c    = {{16{w_half[15]}}, w_half};
                o_illegal_c = i_addr[0];
            end
            LHU: begin
                o_data_c    = {16'h0000, w_half};
                o_illegal_c = i_addr[0];
            end
            LW:      o_illegal_c = |i_addr;
            default: o_illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Writeback stage: merges ALU results and multi-cycle loads onto the single
// register-file write port, ALU first; owns the memory read handshake.
module load_writeback_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned TO_W        = 7
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       alu_wb_en,
    input  index_t     alu_rd,
    input  word_t      alu_result,
    input  logic       ld_req,
    input  index_t     ld_rd,
    input  logic [2:0] ld_funct3,
    input  word_t      ld_addr,
    output logic       ld_busy,
    output index_t     busy_rd,
    output logic       mem_ren,
    output word_t      mem_addr,
    input  logic       mem_ack,
    input  word_t      mem_rdata,
    output logic       reg_write,
    output index_t     write_index,
    output word_t      write_data,
    output logic       ld_error
);

    ld_state_t       r_state, w_state_nx;
    ld_ctx_t         r_ctx, w_ctx_nx;
    word_t           r_data, w_data_nx;
    logic            r_cancel, w_cancel_nx;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nx;

    logic   w_mem_ren_nx, w_reg_write_nx, w_ld_error_nx, w_alu_hits_load;
    word_t  w_mem_addr_nx, w_write_data_nx, w_al_data;
    index_t w_write_index_nx, w_busy_rd_nx;
    logic [2:0] w_al_funct3;
    logic [1:0] w_al_lane;
    logic       w_al_illegal;

    // In IDLE the aligner checks the incoming request; afterwards it decodes the returned word.
    assign w_al_funct3 = (r_state == IDLE) ? ld_funct3    : r_ctx.funct3;
    assign w_al_lane   = (r_state == IDLE) ? ld_addr[1:0] : r_ctx.lane;

    load_align u_align (
        .i_funct3    (w_al_funct3),
        .i_addr      (w_al_lane),
        .i_rdata     (mem_rdata),
        .o_data_c    (w_al_data),
        .o_illegal_c (w_al_illegal)
    );

    assign w_alu_hits_load = alu_wb_en && (busy_rd != '0) && (alu_rd == busy_rd);

    always_comb begin
        w_state_nx       = r_state;
        w_ctx_nx         = r_ctx;
        w_data_nx        = r_data;
        w_cancel_nx      = r_cancel;
        w_to_cnt_nx      = r_to_cnt;
        w_busy_rd_nx     = busy_rd;
        w_mem_ren_nx     = mem_ren;
        w_mem_addr_nx    = mem_addr;
        w_reg_write_nx   = 1'b0;
        w_write_index_nx = '0;
        w_write_data_nx  = '0;
        w_ld_error_nx    = 1'b0;

        if (alu_wb_en && (alu_rd != '0)) begin
            w_reg_write_nx   = 1'b1;
            w_write_index_nx = alu_rd;
            w_write_data_nx  = alu_result;
        end

        case (r_state)
            IDLE: begin
                if (ld_req) begin
                    if (w_al_illegal) begin
                        w_ld_error_nx = 1'b1;
                    end else begin
                        w_state_nx    = REQ;
                        w_ctx_nx      = '{funct3: ld_funct3, lane: ld_addr[1:0]};
                        w_busy_rd_nx  = ld_rd;
                        w_cancel_nx   = 1'b0;
                        w_to_cnt_nx   = '0;
                        w_mem_ren_nx  = 1'b1;
                        w_mem_addr_nx = {ld_addr[31:2], 2'b00};
                    end
                end
            end
            REQ: begin
                if (w_alu_hits_load) w_cancel_nx = 1'b1;
                if (mem_ack) begin
                    w_data_nx     = w_al_data;
                    w_mem_ren_nx  = 1'b0;
                    w_mem_addr_nx = '0;
                    w_state_nx    = WB;
                end else if (r_to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                    w_ld_error_nx = 1'b1;
                    w_mem_ren_nx  = 1'b0;
                    w_mem_addr_nx = '0;
                    w_busy_rd_nx  = '0;
                    w_cancel_nx   = 1'b0;
                    w_state_nx    = IDLE;
                end else begin
                    w_to_cnt_nx = r_to_cnt + TO_W'(1);
                end
            end
            WB: begin
                if (w_alu_hits_load) w_cancel_nx = 1'b1;
                // The load only gets the port on a cycle with no ALU result.
                if (!alu_wb_en) begin
                    if (!r_cancel && (busy_rd != '0)) begin
                        w_reg_write_nx   = 1'b1;
                        w_write_index_nx = busy_rd;
                        w_write_data_nx  = r_data;
                    end
                    w_busy_rd_nx = '0;
                    w_cancel_nx  = 1'b0;
                    w_state_nx   = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= IDLE;
            r_ctx       <= '0;
            r_data      <= '0;
            r_cancel    <= 1'b0;
            r_to_cnt    <= '0;
            ld_busy     <= 1'b0;
            busy_rd     <= '0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
            reg_write   <= 1'b0;
            write_index <= '0;
            write_data  <= '0;
            ld_error    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ctx       <= w_ctx_nx;
            r_data      <= w_data_nx;
            r_cancel    <= w_cancel_nx;
            r_to_cnt    <= w_to_cnt_nx;
            ld_busy     <= (w_state_nx != IDLE);
            busy_rd     <= w_busy_rd_nx;
            mem_ren     <= w_mem_ren_nx;
            mem_addr    <= w_mem_addr_nx;
            reg_write   <= w_reg_write_nx;
            write_index <= w_write_index_nx;
            write_data  <= w_write_data_nx;
            ld_error    <= w_ld_error_nx;
        end
    end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: directed scenarios then randomized
// load/ALU traffic checked against a register-file-level reference model.
module tb_load_writeback_unit;
    import cpu_types_pkg::*;

    logic        clk = 1'b0;
    logic        nRst;
    logic        alu_wb_en;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_req;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_addr;
    logic        ld_busy;
    logic [4:0]  busy_rd;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        reg_write;
    logic [4:0]  write_index;
    logic [31:0] write_data;
    logic        ld_error;

    load_writeback_unit #(.MEM_TIMEOUT(64), .TO_W(7)) dut (
        .clk(clk), .nRst(nRst),
        .alu_wb_en(alu_wb_en), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_req(ld_req), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr(ld_addr),
        .ld_busy(ld_busy), .busy_rd(busy_rd),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
        .ld_error(ld_error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_writes = 0;
    logic [31:0] rf_model [32];
    logic [31:0] rf_dut   [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample just after the edge and shadow any register write.
    task automatic tick();
        @(posedge clk);
        #1;
        if (reg_write) begin
            rf_dut[write_index] = write_data;
            n_writes++;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, ".reg_write"},   32'(reg_write),   32'd0);
        check({pfx, ".write_index"}, 32'(write_index), 32'd0);
        check({pfx, ".write_data"},  write_data,       32'd0);
        check({pfx, ".mem_ren"},     32'(mem_ren),     32'd0);
        check({pfx, ".mem_addr"},    mem_addr,         32'd0);
        check({pfx, ".ld_busy"},     32'(ld_busy),     32'd0);
        check({pfx, ".busy_rd"},     32'(busy_rd),     32'd0);
        check({pfx, ".ld_error"},    32'(ld_error),    32'd0);
    endtask

    task automatic start_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr);
        ld_req = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr = addr;
        tick();
        ld_req = 1'b0;
    endtask

    // Reference: RV32I load semantics computed arithmetically from the byte lane.
    function automatic logic ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] rdata, output logic [31:0] data);
        int unsigned lane;
        longint      v;
        logic [31:0] sh;
        logic        ok;
        lane = addr % 4;
        sh   = rdata >> (8 * lane);
        data = '0;
        ok   = 1'b0;
        case (f3)
            3'd0, 3'd4: begin
                v = longint'(sh % 256);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
                data = 32'(v);
                ok   = 1'b1;
            end
            3'd1, 3'd5: begin
                if (lane % 2 == 0) begin
                    v = longint'(sh % 65536);
                    if (f3 == 3'd1 && v >= 32768) v = v - 65536;
                    data = 32'(v);
                    ok   = 1'b1;
                end
            end
            3'd2: begin
                if (lane == 0) begin
                    data = rdata;
                    ok   = 1'b1;
                end
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    task automatic rand_alu(input logic allow, input logic in_flight, input logic [4:0] lrd,
                            inout logic cancel);
        alu_wb_en  = allow && ($urandom_range(0, 99) < 40);
        alu_rd     = 5'($urandom_range(0, 7));
        alu_result = $urandom;
        if (alu_wb_en) begin
            if (alu_rd != 5'd0) rf_model[alu_rd] = alu_result;
            if (in_flight && lrd != 5'd0 && alu_rd == lrd) cancel = 1'b1;
        end
    endtask

    initial begin
        int          cyc;
        int          wr0;
        logic [4:0]  lrd;
        logic [2:0]  f3;
        logic [31:0] addr, rdata, exp_d;
        logic        legal, cancel;
        int          dly;

        nRst = 1'b0; alu_wb_en = 1'b0; alu_rd = '0; alu_result = '0;
        ld_req = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 32; i++) begin rf_model[i] = '0; rf_dut[i] = '0; end

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) nRst = 1'b1;
        tick();

        // ALU writes, including the x0 suppression
        alu_wb_en = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
        tick();
        check("alu.we",   32'(reg_write),   32'd1);
        check("alu.idx",  32'(write_index), 32'd5);
        check("alu.data", write_data,       32'hDEADBEEF);
        alu_rd = 5'd0;
        tick();
        check("alu.x0_we", 32'(reg_write), 32'd0);
        alu_wb_en = 1'b0;
        tick();

        // LB sign-extend, ack on the third request cycle
        mem_rdata = 32'h80FF1234;
        start_load(5'd7, 3'b000, 32'h103);
        check("lb.ren",     32'(mem_ren), 32'd1);
        check("lb.addr",    mem_addr,     32'h100);
        check("lb.busy",    32'(ld_busy), 32'd1);
        check("lb.busy_rd", 32'(busy_rd), 32'd7);
        tick(); tick();
        check("lb.ren_hold",  32'(mem_ren), 32'd1);
        check("lb.addr_hold", mem_addr,     32'h100);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("lb.ren_drop", 32'(mem_ren),   32'd0);
        check("lb.no_early", 32'(reg_write), 32'd0);
        check("lb.busy_wb",  32'(ld_busy),   32'd1);
        tick();
        check("lb.we",        32'(reg_write),   32'd1);
        check("lb.idx",       32'(write_index), 32'd7);
        check("lb.data",      write_data,       32'hFFFFFF80);
        check("lb.busy_done", 32'(ld_busy),     32'd0);
        check("lb.rd_done",   32'(busy_rd),     32'd0);

        // LBU zero-extend
        start_load(5'd7, 3'b100, 32'h103);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
        check("lbu.we",   32'(reg_write), 32'd1);
        check("lbu.data", write_data,     32'h00000080);

        // LH on upper halfword
        mem_rdata = 32'h8001ABCD;
        start_load(5'd9, 3'b001, 32'h102);
        check("lh.addr", mem_addr, 32'h100);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
        check("lh.idx",  32'(write_index), 32'd9);
        check("lh.data", write_data,       32'hFFFF8001);

        // Misaligned LH is rejected in IDLE
        start_load(5'd9, 3'b001, 32'h101);
        check("lh_mis.err",  32'(ld_error), 32'd1);
        check("lh_mis.ren",  32'(mem_ren),  32'd0);
        check("lh_mis.busy", 32'(ld_busy),  32'd0);
        tick();
        check("lh_mis.pulse", 32'(ld_error), 32'd0);

        // ALU priority over a waiting load
        mem_rdata = 32'hCAFEF00D;
        start_load(5'd3, 3'b010, 32'h300);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        alu_wb_en = 1'b1; alu_rd = 5'd4; alu_result = 32'h000000A1;
        tick();
        check("prio.w1_idx",  32'(write_index), 32'd4);
        check("prio.w1_data", write_data,       32'h000000A1);
        check("prio.w1_busy", 32'(ld_busy),     32'd1);
        alu_result = 32'h000000A2;
        tick();
        check("prio.w2_data", write_data, 32'h000000A2);
        alu_wb_en = 1'b0;
        tick();
        check("prio.ld_we",   32'(reg_write),   32'd1);
        check("prio.ld_idx",  32'(write_index), 32'd3);
        check("prio.ld_data", write_data,       32'hCAFEF00D);
        check("prio.busy",    32'(ld_busy),     32'd0);

        // WAW cancel: ALU writes the load's destination while it is in flight
        start_load(5'd6, 3'b010, 32'h500);
        alu_wb_en = 1'b1; alu_rd = 5'd6; alu_result = 32'h00000011;
        tick();
        alu_wb_en = 1'b0;
        check("waw.alu_data", write_data, 32'h00000011);
        mem_rdata = 32'h12345678; mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        wr0 = n_writes;
        tick(); tick();
        check("waw.no_write", 32'(n_writes - wr0), 32'd0);
        check("waw.x6",       rf_dut[6],           32'h00000011);
        check("waw.busy",     32'(ld_busy),        32'd0);

        // Timeout with no ack
        start_load(5'd10, 3'b010, 32'h200);
        cyc = 0;
        while (mem_ren && cyc < 200) begin tick(); cyc++; end
        check("to.cycles", 32'(cyc),      32'd64);
        check("to.err",    32'(ld_error), 32'd1);
        check("to.busy",   32'(ld_busy),  32'd0);
        tick();
        check("to.pulse",  32'(ld_error), 32'd0);

        // Asynchronous reset during REQ
        start_load(5'd12, 3'b010, 32'h400);
        tick();
        #2 nRst = 1'b0;
        #1 check_all_zero("rst_mid");
        wr0 = n_writes;
        @(negedge clk) nRst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick(); mem_ack = 1'b0; tick(); tick();
        check("rst_mid.no_write", 32'(n_writes - wr0), 32'd0);
        check("rst_mid.busy",     32'(ld_busy),        32'd0);

        // Randomized traffic against the register-file model
        for (int i = 0; i < 32; i++) begin rf_model[i] = '0; rf_dut[i] = '0; end
        for (int t = 0; t < 60; t++) begin
            lrd   = 5'($urandom_range(0, 7));
            f3    = 3'($urandom_range(0, 7));
            addr  = $urandom;
            rdata = $urandom;
            dly   = $urandom_range(0, 5);
            legal = ref_load(f3, addr, rdata, exp_d);
            cancel = 1'b0;

            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            rand_alu(1'b1, 1'b0, lrd, cancel);
            tick();
            mem_ack = 1'b0;

            ld_req = 1'b1; ld_rd = lrd; ld_funct3 = f3; ld_addr = addr;
            rand_alu(1'b1, 1'b0, lrd, cancel);
            tick();
            ld_req = 1'b0;
            if (!legal) begin
                check("rnd.err", 32'(ld_error), 32'd1);
                check("rnd.ren", 32'(mem_ren),  32'd0);
            end else begin
                check("rnd.ren",     32'(mem_ren), 32'd1);
                check("rnd.addr",    mem_addr,     addr & 32'hFFFFFFFC);
                check("rnd.busy_rd", 32'(busy_rd), 32'(lrd));
                for (int k = 0; k < dly; k++) begin
                    rand_alu(1'b1, 1'b1, lrd, cancel);
                    tick();
                end
                mem_ack = 1'b1; mem_rdata = rdata;
                rand_alu(1'b1, 1'b1, lrd, cancel);
                tick();
                mem_ack = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    rand_alu(k < 19, 1'b1, lrd, cancel);
                    tick();
                    if (!alu_wb_en) break;
                end
                if (!cancel && lrd != 5'd0) rf_model[lrd] = exp_d;
            end
            alu_wb_en = 1'b0;
            check("rnd.busy", 32'(ld_busy), 32'd0);
            for (int r = 0; r < 8; r++)
                check($sformatf("rnd%0d.x%0d", t, r), rf_dut[r], rf_model[r]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
